input_conditioner_bank: RTL and testbench

- Parametrised N-channel replacement for the per-button synchronize/debounce instances in the labkit top level.
- Each channel runs an asynchronous switch or button through a synchroniser, a stability-count debouncer, an edge detector, a toggle latch and an optional hold-to-repeat generator.
- Outputs feed the main FSM, keyboard export and display controls directly as clean levels or single-cycle pulses.

---
 rtl/input_conditioner_bank_if.sv | 23 ++
 rtl/input_conditioner_bank.sv | 158 +++++++++++++++
 tb/tb_input_conditioner_bank.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/input_conditioner_bank_if.sv
// Bus between the raw panel inputs and the conditioned per-channel levels/strobes.
// The master drives the raw inputs; the slave is the conditioner bank.
interface input_conditioner_bank_if #(
    parameter int CHANNELS = 5
);
    logic [CHANNELS-1:0] noisy;
    logic [CHANNELS-1:0] clear_toggle;
    logic [CHANNELS-1:0] clean;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] toggle;
    logic [CHANNELS-1:0] press;

    modport master (
        output noisy, clear_toggle,
        input  clean, rise, fall, toggle, press
    );

    modport slave (
        input  noisy, clear_toggle,
        output clean, rise, fall, toggle, press
    );
endinterface

// File: rtl/input_conditioner_bank.sv
// N independent switch/button conditioners: synchroniser, stability-count debounce,
// edge pulses, toggle latch and hold-to-repeat strobe per channel.
module input_conditioner_bank #(
    parameter int CHANNELS        = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 32500000,
    parameter int REPEAT_PERIOD   = 6500000,
    parameter int RPT_W           = 26
) (
    input logic                     clock,
    input logic                     reset,
    input_conditioner_bank_if.slave bus
);
    localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int               DELAY_LAST_I = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
    localparam logic [RPT_W-1:0] DELAY_LAST   = RPT_W'(DELAY_LAST_I);
    localparam logic [RPT_W-1:0] PERIOD_LAST  = RPT_W'(REPEAT_PERIOD - 1);
    localparam bit               RPT_EN       = (REPEAT_DELAY != 0);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD < 1) begin : g_bad_range
        $error("input_conditioner_bank: parameter below its minimum");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("input_conditioner_bank: CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if ((64'd1 << RPT_W) <= 64'(REPEAT_DELAY) || (64'd1 << RPT_W) <= 64'(REPEAT_PERIOD)) begin : g_bad_rpt_w
        $error("input_conditioner_bank: RPT_W too narrow for repeat timing");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rpt_state_t;

    logic [CHANNELS-1:0] clean_vec;
    logic [CHANNELS-1:0] rise_vec;
    logic [CHANNELS-1:0] fall_vec;
    logic [CHANNELS-1:0] toggle_vec;
    logic [CHANNELS-1:0] press_vec;

    genvar gi;
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_reg;
        logic [CNT_W-1:0]       cnt_reg;
        logic                   clean_reg;
        logic                   rise_reg;
        logic                   fall_reg;
        logic                   toggle_reg;
        logic                   press_reg;
        rpt_state_t             state_reg, state_next;
        logic [RPT_W-1:0]       rpt_reg, rpt_next;
        logic                   stable_in;
        logic                   flip;
        logic                   rise_set;
        logic                   fall_set;
        logic                   rpt_pulse;

        assign stable_in = sync_reg[SYNC_STAGES-1];
        // clean inverts only after DEBOUNCE_CYCLES consecutive disagreeing samples
        assign flip      = (stable_in != clean_reg) && (cnt_reg == DEB_LAST);
        assign rise_set  = flip & ~clean_reg;
        assign fall_set  = flip & clean_reg;

        always_ff @(posedge clock) begin
            if (!reset) begin
                sync_reg   <= '0;
                cnt_reg    <= '0;
                clean_reg  <= 1'b0;
                rise_reg   <= 1'b0;
                fall_reg   <= 1'b0;
                toggle_reg <= 1'b0;
                press_reg  <= 1'b0;
            end else begin
                sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.noisy[gi]};
                if (stable_in == clean_reg || flip) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                clean_reg <= clean_reg ^ flip;
                rise_reg  <= rise_set;
                fall_reg  <= fall_set;
                if (bus.clear_toggle[gi]) begin
                    toggle_reg <= 1'b0;
                end else if (rise_set) begin
                    toggle_reg <= ~toggle_reg;
                end
                press_reg <= rise_set | rpt_pulse;
            end
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                state_reg <= ST_IDLE;
                rpt_reg   <= '0;
            end else begin
                state_reg <= state_next;
                rpt_reg   <= rpt_next;
            end
        end

        always_comb begin
            state_next = state_reg;
            rpt_next   = rpt_reg;
            rpt_pulse  = 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (rise_set && RPT_EN) begin
                        state_next = ST_DELAY;
                        rpt_next   = '0;
                    end
                end
                ST_DELAY: begin
                    if (rpt_reg == DELAY_LAST) begin
                        rpt_pulse  = 1'b1;
                        rpt_next   = '0;
                        state_next = ST_REPEAT;
                    end else begin
                        rpt_next = rpt_reg + RPT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (rpt_reg == PERIOD_LAST) begin
                        rpt_pulse = 1'b1;
                        rpt_next  = '0;
                    end else begin
                        rpt_next = rpt_reg + RPT_W'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    rpt_next   = '0;
                end
            endcase
            // a release cancels any strobe due on the same edge
            if (fall_set) begin
                state_next = ST_IDLE;
                rpt_next   = '0;
                rpt_pulse  = 1'b0;
            end
        end

        assign clean_vec[gi]  = clean_reg;
        assign rise_vec[gi]   = rise_reg;
        assign fall_vec[gi]   = fall_reg;
        assign toggle_vec[gi] = toggle_reg;
        assign press_vec[gi]  = press_reg;
    end

    assign bus.clean  = clean_vec;
    assign bus.rise   = rise_vec;
    assign bus.fall   = fall_vec;
    assign bus.toggle = toggle_vec;
    assign bus.press  = press_vec;
endmodule

// File: tb/tb_input_conditioner_bank.sv
// Directed bench for input_conditioner_bank with 3 channels, 4-cycle debounce,
// repeat delay 10 and period 3; offsets are counted from each channel's rise cycle.
module tb_input_conditioner_bank;
    localparam int CH = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    input_conditioner_bank_if #(.CHANNELS(CH)) bus ();

    input_conditioner_bank #(
        .CHANNELS       (CH),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .RPT_W          (4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] chan_obs(input int c);
        return {bus.clean[c], bus.rise[c], bus.fall[c], bus.press[c]};
    endfunction

    task automatic test_reset();
        logic [14:0] exp;
        logic [14:0] obs;
        reset = 1'b0;
        bus.noisy = 3'b111;
        bus.clear_toggle = 3'b000;
        for (int k = 1; k <= 3; k++) tick();
        obs = {bus.clean, bus.rise, bus.fall, bus.toggle, bus.press};
        vectors++;
        if (obs !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_hold outputs=%b expected=%b", obs, 15'd0);
        end
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = {(k >= 6) ? 3'b111 : 3'b000, (k == 6) ? 3'b111 : 3'b000, 3'b000,
                   (k >= 6) ? 3'b111 : 3'b000, (k == 6) ? 3'b111 : 3'b000};
            obs = {bus.clean, bus.rise, bus.fall, bus.toggle, bus.press};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_release k=%0d outputs=%b expected=%b", k, obs, exp);
            end
        end
        bus.noisy = 3'b000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = {(k >= 6) ? 3'b000 : 3'b111, 3'b000, (k == 6) ? 3'b111 : 3'b000,
                   3'b111, 3'b000};
            obs = {bus.clean, bus.rise, bus.fall, bus.toggle, bus.press};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_fall k=%0d outputs=%b expected=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] exp;
        bus.noisy[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            vectors++;
            if (chan_obs(0) !== 4'b0000) begin
                miscompares++;
                $display("FAIL glitch_3cyc k=%0d obs=%b expected=%b", k, chan_obs(0), 4'b0000);
            end
            if (k == 3) bus.noisy[0] = 1'b0;
        end
        bus.noisy[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp = {k >= 6 && k <= 9, k == 6, k == 10, k == 6};
            vectors++;
            if (chan_obs(0) !== exp) begin
                miscompares++;
                $display("FAIL glitch_4cyc k=%0d obs=%b expected=%b", k, chan_obs(0), exp);
            end
            if (k == 4) bus.noisy[0] = 1'b0;
        end
    endtask

    task automatic test_auto_repeat();
        logic [3:0] exp;
        int off;
        bus.noisy[1] = 1'b1;
        for (int k = 1; k <= 56; k++) begin
            tick();
            off = k - 6;
            exp = {off >= 0 && off < 40, off == 0, off == 40,
                   off == 0 || (off >= 10 && off <= 37 && (off - 10) % 3 == 0)};
            vectors++;
            if (chan_obs(1) !== exp) begin
                miscompares++;
                $display("FAIL auto_repeat off=%0d obs=%b expected=%b", off, chan_obs(1), exp);
            end
            if (k == 40) bus.noisy[1] = 1'b0;
        end
    endtask

    task automatic test_release_in_delay();
        logic [3:0] exp;
        int off;
        bus.noisy[1] = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            tick();
            off = k - 6;
            exp = {off >= 0 && off < 7, off == 0, off == 7, off == 0};
            vectors++;
            if (chan_obs(1) !== exp) begin
                miscompares++;
                $display("FAIL short_hold off=%0d obs=%b expected=%b", off, chan_obs(1), exp);
            end
            if (k == 7) bus.noisy[1] = 1'b0;
        end
        bus.noisy[1] = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            tick();
            off = k - 6;
            exp = {off >= 0 && off < 16, off == 0, off == 16,
                   off == 0 || off == 10 || off == 13};
            vectors++;
            if (chan_obs(1) !== exp) begin
                miscompares++;
                $display("FAIL restart_delay off=%0d obs=%b expected=%b", off, chan_obs(1), exp);
            end
            if (k == 16) bus.noisy[1] = 1'b0;
        end
    endtask

    task automatic test_toggle_clear();
        logic [1:0] obs;
        logic [1:0] exp;
        bus.clear_toggle[2] = 1'b1;
        tick();
        bus.clear_toggle[2] = 1'b0;
        vectors++;
        if (bus.toggle[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL toggle_clear_idle toggle=%b expected=0", bus.toggle[2]);
        end
        for (int p = 1; p <= 3; p++) begin
            bus.noisy[2] = 1'b1;
            for (int k = 1; k <= 5; k++) tick();
            if (p == 3) bus.clear_toggle[2] = 1'b1;
            tick();
            bus.clear_toggle[2] = 1'b0;
            obs = {bus.rise[2], bus.toggle[2]};
            exp = {1'b1, p == 1};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL toggle_press%0d rise_toggle=%b expected=%b", p, obs, exp);
            end
            bus.noisy[2] = 1'b0;
            for (int k = 1; k <= 6; k++) tick();
            obs = {bus.fall[2], bus.toggle[2]};
            exp = {1'b1, p == 1};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL toggle_release%0d fall_toggle=%b expected=%b", p, obs, exp);
            end
        end
    endtask

    task automatic test_independence();
        logic [3:0] exp0;
        logic [3:0] exp1;
        int off;
        int rel1;
        bus.noisy[0] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            off  = k - 6;
            rel1 = off - 3;
            exp0 = {off >= 0 && off < 30, off == 0, off == 30,
                    off == 0 || (off >= 10 && off < 30 && (off - 10) % 3 == 0)};
            exp1 = {rel1 >= 0 && off < 30, rel1 == 0, off == 30,
                    rel1 == 0 || (rel1 >= 10 && off < 30 && (rel1 - 10) % 3 == 0)};
            vectors++;
            if (chan_obs(0) !== exp0) begin
                miscompares++;
                $display("FAIL indep_ch0 off=%0d obs=%b expected=%b", off, chan_obs(0), exp0);
            end
            vectors++;
            if (chan_obs(1) !== exp1) begin
                miscompares++;
                $display("FAIL indep_ch1 off=%0d obs=%b expected=%b", off, chan_obs(1), exp1);
            end
            if (k == 3) bus.noisy[1] = 1'b1;
            if (k == 30) bus.noisy[1:0] = 2'b00;
        end
    endtask

    initial begin
        bus.noisy = '0;
        bus.clear_toggle = '0;
        test_reset();
        test_glitch();
        test_auto_repeat();
        test_release_in_delay();
        test_toggle_clear();
        test_independence();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
